// File: rtl/dispatch_tag_alloc_if.sv
// Dispatch tag allocator bundle: decode, tag FIFO, retire bus and issue-side signals.
// Stall_Cnt exists only when STALL_COUNT_EN is defined.
interface dispatch_tag_alloc_if #(
  parameter int DSIZE = 5,
  parameter int RSIZE = 5,
  parameter int CSIZE = 6
);
  logic             Ins_Valid;
  logic             Ins_Ready;
  logic             Ins_Has_Rd;
  logic [RSIZE-1:0] Ins_Rd;
  logic [RSIZE-1:0] Ins_Rs;
  logic [RSIZE-1:0] Ins_Rt;
  logic [DSIZE-1:0] Tag_In;
  logic             Tag_Empty;
  logic             Tag_Rd_en;
  logic             Tag_Increment;
  logic [DSIZE-1:0] RB_Tag;
  logic             RB_Tag_Valid;
  logic [RSIZE-1:0] RB_Rd;
  logic             Disp_Valid;
  logic             Disp_Ready;
  logic             Disp_Has_Rd;
  logic [DSIZE-1:0] Disp_Tag;
  logic             Disp_Rs_Busy;
  logic [DSIZE-1:0] Disp_Rs_Tag;
  logic             Disp_Rt_Busy;
  logic [DSIZE-1:0] Disp_Rt_Tag;
  logic [CSIZE-1:0] Outstanding;
`ifdef STALL_COUNT_EN
  logic [15:0]      Stall_Cnt;
`endif

  modport slave (
`ifdef STALL_COUNT_EN
    output Stall_Cnt,
`endif
    input  Ins_Valid, Ins_Has_Rd, Ins_Rd, Ins_Rs, Ins_Rt, Tag_In, Tag_Empty,
    input  RB_Tag, RB_Tag_Valid, RB_Rd, Disp_Ready,
    output Ins_Ready, Tag_Rd_en, Tag_Increment, Disp_Valid, Disp_Has_Rd, Disp_Tag,
    output Disp_Rs_Busy, Disp_Rs_Tag, Disp_Rt_Busy, Disp_Rt_Tag, Outstanding
  );

  modport master (
`ifdef STALL_COUNT_EN
    input  Stall_Cnt,
`endif
    output Ins_Valid, Ins_Has_Rd, Ins_Rd, Ins_Rs, Ins_Rt, Tag_In, Tag_Empty,
    output RB_Tag, RB_Tag_Valid, RB_Rd, Disp_Ready,
    input  Ins_Ready, Tag_Rd_en, Tag_Increment, Disp_Valid, Disp_Has_Rd, Disp_Tag,
    input  Disp_Rs_Busy, Disp_Rs_Tag, Disp_Rt_Busy, Disp_Rt_Tag, Outstanding
  );
endinterface

// File: rtl/dispatch_tag_alloc.sv
// Dispatch-side tag allocator: pops tags, maintains the register status table and
// registers the renamed instruction for issue. STALL_COUNT_EN adds a stall counter.
module dispatch_tag_alloc #(
  parameter int DSIZE = 5,
  parameter int RSIZE = 5,
  parameter int CSIZE = 6
) (
  input logic              clock,
  input logic              reset,
  dispatch_tag_alloc_if.slave bus
);
  localparam int NREG = 2 ** RSIZE;
  localparam logic [CSIZE-1:0] TAG_MAX = CSIZE'(2 ** DSIZE);

  logic [DSIZE-1:0] rst_tag [NREG];
  logic [NREG-1:0]  rst_vld;

  logic             vld_p1;
  logic             has_rd_p1;
  logic [DSIZE-1:0] tag_p1;
  logic             rs_busy_p1;
  logic [DSIZE-1:0] rs_tag_p1;
  logic             rt_busy_p1;
  logic [DSIZE-1:0] rt_tag_p1;
  logic [CSIZE-1:0] outstanding;

  logic need_tag, ins_ready, accept, pop;
  logic rs_busy, rt_busy, rb_hit;

  function automatic logic [CSIZE-1:0] count_next(input logic [CSIZE-1:0] c,
                                                  input logic inc, input logic dec);
    if (inc && !dec) return (c == TAG_MAX) ? c : c + 1'b1;
    if (dec && !inc) return (c == '0) ? c : c - 1'b1;
    return c;
  endfunction

  // A source is busy unless it is r0, unmapped, or its producer retires this very cycle.
  function automatic logic src_busy(input logic [RSIZE-1:0] src);
    logic bypass;
    bypass = bus.RB_Tag_Valid && (bus.RB_Rd == src) && (rst_tag[src] == bus.RB_Tag);
    return (src != '0) && rst_vld[src] && !bypass;
  endfunction

  assign need_tag  = bus.Ins_Has_Rd && (bus.Ins_Rd != '0);
  assign ins_ready = (!vld_p1 || bus.Disp_Ready) && !(need_tag && bus.Tag_Empty) && !reset;
  assign accept    = bus.Ins_Valid && ins_ready;
  assign pop       = accept && need_tag;
  assign rs_busy   = src_busy(bus.Ins_Rs);
  assign rt_busy   = src_busy(bus.Ins_Rt);
  assign rb_hit    = bus.RB_Tag_Valid && rst_vld[bus.RB_Rd] && (rst_tag[bus.RB_Rd] == bus.RB_Tag);

  assign bus.Ins_Ready     = ins_ready;
  assign bus.Tag_Rd_en     = pop;
  assign bus.Tag_Increment = pop;

  // Register status table; the dispatch write is applied last so it wins over a retire clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      rst_vld <= '0;
      for (int i = 0; i < NREG; i++) rst_tag[i] <= '0;
    end else begin
      if (rb_hit) rst_vld[bus.RB_Rd] <= 1'b0;
      if (pop) begin
        rst_vld[bus.Ins_Rd] <= 1'b1;
        rst_tag[bus.Ins_Rd] <= bus.Tag_In;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) outstanding <= '0;
    else       outstanding <= count_next(outstanding, pop, bus.RB_Tag_Valid);
  end

  // p1: registered dispatch stage toward issue
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      has_rd_p1  <= 1'b0;
      tag_p1     <= '0;
      rs_busy_p1 <= 1'b0;
      rs_tag_p1  <= '0;
      rt_busy_p1 <= 1'b0;
      rt_tag_p1  <= '0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      has_rd_p1  <= need_tag;
      tag_p1     <= need_tag ? bus.Tag_In : '0;
      rs_busy_p1 <= rs_busy;
      rs_tag_p1  <= rs_busy ? rst_tag[bus.Ins_Rs] : '0;
      rt_busy_p1 <= rt_busy;
      rt_tag_p1  <= rt_busy ? rst_tag[bus.Ins_Rt] : '0;
    end else if (bus.Disp_Ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.Disp_Valid   = vld_p1;
  assign bus.Disp_Has_Rd  = has_rd_p1;
  assign bus.Disp_Tag     = tag_p1;
  assign bus.Disp_Rs_Busy = rs_busy_p1;
  assign bus.Disp_Rs_Tag  = rs_tag_p1;
  assign bus.Disp_Rt_Busy = rt_busy_p1;
  assign bus.Disp_Rt_Tag  = rt_tag_p1;
  assign bus.Outstanding  = outstanding;

`ifdef STALL_COUNT_EN
  logic [15:0] stall_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) stall_cnt <= '0;
    else if (bus.Ins_Valid && need_tag && bus.Tag_Empty) stall_cnt <= sat_inc16(stall_cnt);
  end

  assign bus.Stall_Cnt = stall_cnt;
`endif
endmodule

// File: tb/tb_dispatch_tag_alloc.sv
// Directed bench for dispatch_tag_alloc; expected values are hand-computed per step.
module tb_dispatch_tag_alloc;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  dispatch_tag_alloc_if bus ();

  dispatch_tag_alloc dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int v, input int has, input int rd, input int rs, input int rt,
                       input int tag);
    bus.Ins_Valid  = 1'(v);
    bus.Ins_Has_Rd = 1'(has);
    bus.Ins_Rd     = 5'(rd);
    bus.Ins_Rs     = 5'(rs);
    bus.Ins_Rt     = 5'(rt);
    bus.Tag_In     = 5'(tag);
  endtask

  task automatic retire(input int v, input int tag, input int rd);
    bus.RB_Tag_Valid = 1'(v);
    bus.RB_Tag       = 5'(tag);
    bus.RB_Rd        = 5'(rd);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    retire(0, 0, 0);
    bus.Tag_Empty  = 1'b0;
    bus.Disp_Ready = 1'b1;
    step();
    step();
    chk("reset_ins_ready", 32'(bus.Ins_Ready), 0);
    chk("reset_disp_valid", 32'(bus.Disp_Valid), 0);
    chk("reset_outstanding", 32'(bus.Outstanding), 0);
    chk("reset_disp_tag", 32'(bus.Disp_Tag), 0);
    reset = 1'b0;

    // First allocation: r3 gets tag 0
    drive(1, 1, 3, 0, 0, 0);
    #1;
    chk("pop_rd_en", 32'(bus.Tag_Rd_en), 1);
    chk("pop_increment", 32'(bus.Tag_Increment), 1);
    step();
    chk("first_valid", 32'(bus.Disp_Valid), 1);
    chk("first_tag", 32'(bus.Disp_Tag), 0);
    chk("first_has_rd", 32'(bus.Disp_Has_Rd), 1);
    chk("first_outstanding", 32'(bus.Outstanding), 1);

    drive(1, 1, 5, 0, 0, 7);
    step();
    chk("r5_tag", 32'(bus.Disp_Tag), 7);
    chk("r5_outstanding", 32'(bus.Outstanding), 2);

    drive(1, 0, 0, 5, 3, 7);
    step();
    chk("rs5_busy", 32'(bus.Disp_Rs_Busy), 1);
    chk("rs5_tag", 32'(bus.Disp_Rs_Tag), 7);
    chk("rt3_busy", 32'(bus.Disp_Rt_Busy), 1);
    chk("rt3_tag", 32'(bus.Disp_Rt_Tag), 0);
    chk("nord_has_rd", 32'(bus.Disp_Has_Rd), 0);
    chk("nord_tag", 32'(bus.Disp_Tag), 0);

    // Retire bypass on lookup
    drive(1, 0, 0, 5, 0, 7);
    retire(1, 7, 5);
    step();
    retire(0, 0, 0);
    chk("bypass_rs_busy", 32'(bus.Disp_Rs_Busy), 0);
    chk("bypass_rs_tag", 32'(bus.Disp_Rs_Tag), 0);
    chk("rt0_busy", 32'(bus.Disp_Rt_Busy), 0);
    chk("bypass_outstanding", 32'(bus.Outstanding), 1);

    drive(1, 1, 2, 5, 0, 4);
    step();
    chk("r5_cleared", 32'(bus.Disp_Rs_Busy), 0);
    chk("r2a_outstanding", 32'(bus.Outstanding), 2);

    drive(1, 1, 2, 2, 0, 9);
    step();
    chk("rs_eq_rd_busy", 32'(bus.Disp_Rs_Busy), 1);
    chk("rs_eq_rd_old_tag", 32'(bus.Disp_Rs_Tag), 4);
    chk("r2b_tag", 32'(bus.Disp_Tag), 9);
    chk("r2b_outstanding", 32'(bus.Outstanding), 3);

    // Stale retire of tag 4 must not clear r2 (now tag 9)
    drive(1, 0, 0, 2, 0, 0);
    retire(1, 4, 2);
    step();
    chk("stale_lookup_busy", 32'(bus.Disp_Rs_Busy), 1);
    chk("stale_lookup_tag", 32'(bus.Disp_Rs_Tag), 9);
    chk("stale_outstanding", 32'(bus.Outstanding), 2);
    retire(0, 0, 0);
    step();
    chk("stale_kept_busy", 32'(bus.Disp_Rs_Busy), 1);
    chk("stale_kept_tag", 32'(bus.Disp_Rs_Tag), 9);

    drive(0, 0, 0, 0, 0, 0);
    retire(1, 9, 2);
    step();
    retire(0, 0, 0);
    chk("idle_valid_drops", 32'(bus.Disp_Valid), 0);
    chk("r2_retire_outstanding", 32'(bus.Outstanding), 1);
    drive(1, 0, 0, 2, 0, 0);
    step();
    chk("r2_cleared", 32'(bus.Disp_Rs_Busy), 0);

    // Tag FIFO empty stalls only instructions that need a tag
    bus.Tag_Empty = 1'b1;
    drive(1, 1, 6, 0, 0, 3);
    #1;
    chk("empty_ready", 32'(bus.Ins_Ready), 0);
    chk("empty_no_pop", 32'(bus.Tag_Rd_en), 0);
    repeat (5) step();
    chk("empty_valid", 32'(bus.Disp_Valid), 0);
    chk("empty_outstanding", 32'(bus.Outstanding), 1);
`ifdef STALL_COUNT_EN
    chk("stall_cnt_5", 32'(bus.Stall_Cnt), 5);
`endif

    drive(1, 0, 0, 0, 0, 31);
    #1;
    chk("empty_nord_ready", 32'(bus.Ins_Ready), 1);
    step();
    chk("empty_nord_valid", 32'(bus.Disp_Valid), 1);
    chk("empty_nord_has_rd", 32'(bus.Disp_Has_Rd), 0);
    chk("empty_nord_tag", 32'(bus.Disp_Tag), 0);
`ifdef STALL_COUNT_EN
    chk("stall_cnt_hold", 32'(bus.Stall_Cnt), 5);
`endif

    drive(1, 1, 0, 0, 0, 31);
    #1;
    chk("r0_ready", 32'(bus.Ins_Ready), 1);
    chk("r0_no_pop", 32'(bus.Tag_Rd_en), 0);
    step();
    chk("r0_has_rd", 32'(bus.Disp_Has_Rd), 0);
    chk("r0_outstanding", 32'(bus.Outstanding), 1);

    // Back-pressure from issue holds the stage
    bus.Tag_Empty  = 1'b0;
    bus.Disp_Ready = 1'b0;
    drive(1, 1, 7, 3, 0, 12);
    #1;
    chk("bp_ready", 32'(bus.Ins_Ready), 0);
    chk("bp_no_pop", 32'(bus.Tag_Rd_en), 0);
    step();
    chk("bp_valid_held", 32'(bus.Disp_Valid), 1);
    chk("bp_has_rd_held", 32'(bus.Disp_Has_Rd), 0);
    chk("bp_outstanding", 32'(bus.Outstanding), 1);
    bus.Disp_Ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.Ins_Ready), 1);
    step();
    chk("bp_load_valid", 32'(bus.Disp_Valid), 1);
    chk("bp_load_tag", 32'(bus.Disp_Tag), 12);
    chk("bp_load_rs3_busy", 32'(bus.Disp_Rs_Busy), 1);
    chk("bp_load_outstanding", 32'(bus.Outstanding), 2);

    drive(1, 1, 8, 0, 0, 13);
    step();
    chk("b2b_tag", 32'(bus.Disp_Tag), 13);
    chk("b2b_outstanding", 32'(bus.Outstanding), 3);

    drive(1, 1, 9, 0, 0, 14);
    retire(1, 12, 7);
    step();
    chk("pop_and_retire", 32'(bus.Outstanding), 3);

    // Dispatch write to r8 and retire of r8's old tag in one cycle
    drive(1, 1, 8, 0, 0, 20);
    retire(1, 13, 8);
    step();
    retire(0, 0, 0);
    chk("collide_outstanding", 32'(bus.Outstanding), 3);
    drive(1, 0, 0, 8, 7, 0);
    step();
    chk("collide_rs8_busy", 32'(bus.Disp_Rs_Busy), 1);
    chk("collide_rs8_tag", 32'(bus.Disp_Rs_Tag), 20);
    chk("rt7_retired", 32'(bus.Disp_Rt_Busy), 0);

    for (int i = 0; i < 29; i++) begin
      drive(1, 1, 10, 0, 0, i);
      step();
    end
    chk("outstanding_32", 32'(bus.Outstanding), 32);
    drive(1, 1, 10, 0, 0, 29);
    step();
    chk("outstanding_sat", 32'(bus.Outstanding), 32);

    // Reset while an instruction is held
    bus.Disp_Ready = 1'b0;
    reset = 1'b1;
    drive(1, 1, 11, 0, 0, 5);
    #1;
    chk("rst_mid_no_pop", 32'(bus.Tag_Rd_en), 0);
    chk("rst_mid_ready", 32'(bus.Ins_Ready), 0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    bus.Disp_Ready = 1'b1;
    chk("rst_mid_valid", 32'(bus.Disp_Valid), 0);
    chk("rst_mid_outstanding", 32'(bus.Outstanding), 0);
    chk("rst_mid_tag", 32'(bus.Disp_Tag), 0);
`ifdef STALL_COUNT_EN
    chk("rst_mid_stall_cnt", 32'(bus.Stall_Cnt), 0);
`endif

    retire(1, 20, 8);
    step();
    retire(0, 0, 0);
    chk("retire_at_zero", 32'(bus.Outstanding), 0);
    drive(1, 0, 0, 8, 0, 0);
    step();
    chk("rst_cleared_table", 32'(bus.Disp_Rs_Busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dispatch_tag_alloc.md
Name: dispatch_tag_alloc

Overview:
Dispatch-side tag allocator. It sits directly downstream of the 32-entry tag FIFO and consumes its tags. For each instruction it pops a tag when the instruction has a destination register, records the tag in a 32-entry register status table (RST), and looks up the current producer tags of the two source registers. It presents the renamed instruction to the issue stage through a registered valid/ready stage, and uses retire-bus publications to clear RST entries.

Parameters:
DSIZE, 5, tag width (32 tags)
RSIZE, 5, architectural register index width (32 registers)
CSIZE, 6, outstanding-tag counter width (holds 0..32)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
Ins_Valid  in  1  decoded instruction valid
Ins_Ready  out  1  instruction accepted this cycle when Ins_Valid&&Ins_Ready
Ins_Has_Rd  in  1  instruction writes a destination register
Ins_Rd  in  RSIZE  destination register
Ins_Rs  in  RSIZE  source register 1
Ins_Rt  in  RSIZE  source register 2
Tag_In  in  DSIZE  head tag from tag FIFO (combinational read)
Tag_Empty  in  1  tag FIFO empty
Tag_Rd_en  out  1  pop request to tag FIFO
Tag_Increment  out  1  pop qualifier to tag FIFO, equal to Tag_Rd_en
RB_Tag  in  DSIZE  retiring tag
RB_Tag_Valid  in  1  retire bus valid
RB_Rd  in  RSIZE  destination register of retiring tag
Disp_Valid  out  1  renamed instruction valid
Disp_Ready  in  1  issue stage accepts
Disp_Has_Rd  out  1  destination allocated
Disp_Tag  out  DSIZE  allocated tag (0 when Disp_Has_Rd=0)
Disp_Rs_Busy  out  1  Rs waits on an in-flight tag
Disp_Rs_Tag  out  DSIZE  producer tag of Rs (0 when not busy)
Disp_Rt_Busy  out  1  Rt waits on an in-flight tag
Disp_Rt_Tag  out  DSIZE  producer tag of Rt (0 when not busy)
Outstanding  out  CSIZE  number of tags currently allocated

Behaviour:
- Reset (sync): all RST entries invalid with tag 0; all Disp_* outputs 0; Outstanding=0. Reset mid-operation drops the held instruction and performs no pop.
- need_tag = Ins_Has_Rd && (Ins_Rd!=0). Register 0 is never renamed; no tag is consumed for it.
- Ins_Ready = (!Disp_Valid || Disp_Ready) && !(need_tag && Tag_Empty) && !reset. This is combinational and depends on Ins_Has_Rd/Ins_Rd.
- accept = Ins_Valid && Ins_Ready. Tag_Rd_en = Tag_Increment = accept && need_tag, same cycle. Tag_In is captured into Disp_Tag at that clock edge, so latency is 1 cycle from accept to Disp_Valid.
- Output stage: on accept, load Disp_* and set Disp_Valid=1. Otherwise, when Disp_Ready=1, clear Disp_Valid=0. Otherwise hold all Disp_* outputs. Back-to-back accepts give 1 instruction/cycle.
- Source lookup uses the pre-update RST, so an instruction whose Rs==Rd sees the older producer. Register 0 always reads not busy.
- Retire bypass on lookup: if RB_Tag_Valid && RB_Rd==src && RST[src].tag==RB_Tag in the same cycle, report the source not busy.
- RST write: on accept with need_tag, RST[Ins_Rd] <= {valid=1, Tag_In}.
- RST clear: on RB_Tag_Valid, clear RST[RB_Rd] only if it is valid and its tag equals RB_Tag. A stale tag, from a register renamed again, leaves the entry unchanged.
- Same-cycle dispatch write and retire clear to the same register: the dispatch write wins.
- Outstanding: +1 on a pop, -1 on RB_Tag_Valid, net 0 when both occur. The counter saturates at 0 and at 32; an RB_Tag_Valid while at 0 is ignored.

Optional Feature:
STALL_COUNT_EN
- Defined: adds output Stall_Cnt [15:0]. It increments on each cycle with Ins_Valid && need_tag && Tag_Empty, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then Ins_Valid with Has_Rd=1, Rd=3 and Tag_In=0 -> Tag_Rd_en=1 that cycle; next cycle Disp_Valid=1, Disp_Tag=0, Outstanding=1, RST[3]={1,0}.
- Dispatch Rd=5 (tag 7), then Rs=5, Rt=0 -> Disp_Rs_Busy=1, Disp_Rs_Tag=7, Disp_Rt_Busy=0; repeat with RB_Tag=7, RB_Rd=5 in the same cycle -> Disp_Rs_Busy=0.
- Rename r2 to tag 4, then to tag 9; retire tag 4 on RB_Rd=2 -> RST[2] stays {1,9}; retire tag 9 -> RST[2] invalid.
- Tag_Empty=1 with Has_Rd=1 -> Ins_Ready=0, no pop; Has_Rd=0 with Tag_Empty=1 -> accepted, Disp_Has_Rd=0, Disp_Tag=0.
- Disp_Ready=0 while Disp_Valid=1 -> Ins_Ready=0 and outputs held; Disp_Ready=1 with Ins_Valid -> new instruction loaded, no bubble.
- 32 pops with no retires -> Outstanding=32; a pop and a retire in the same cycle -> Outstanding unchanged; with STALL_COUNT_EN, 5 stalled cycles -> Stall_Cnt=5.
